// File: rtl/d_sram_like_bridge_pkg.sv
// Shared definitions for the sram-like bus bridges: FSM encoding, bus size codes
// and a helper that classifies legal byte-enable patterns.
package d_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Reads (0000), single bytes, aligned halves and full words are the only shapes the core emits.
    function automatic logic wen_legal(input logic [3:0] wen);
        case (wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/d_bridge_size_dec.sv
// Turns byte enables + CPU address into bus size and bus address; combinational.
// Kseg0/kseg1 folding to physical is compiled in with D_BRIDGE_KSEG_MAP_EN.
module d_bridge_size_dec
    import d_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [3:0]        wen,
    input  logic [31:0]       addr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] bus_addr
);

    logic [31:0] phys;

    always_comb begin
        phys = addr;
`ifdef D_BRIDGE_KSEG_MAP_EN
        if (addr[31:30] == 2'b10) begin
            phys = {3'b000, addr[28:0]};
        end
`else
`endif
    end

    always_comb begin
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
            4'b0011, 4'b1100:                   size = SIZE_HALF;
            default:                            size = SIZE_WORD;
        endcase
    end

    // Reads always fetch the whole aligned word; the core picks the lane itself.
    always_comb begin
        if (wen == 4'b0000) begin
            bus_addr = {phys[ADDR_W-1:2], 2'b00};
        end else begin
            bus_addr = phys[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/d_sram_like_bridge.sv
// Purpose: single-cycle CPU data sram port -> sram-like req/addr_ok/data_ok bus; optional kseg map (D_BRIDGE_KSEG_MAP_EN).
// Latency: 3 stall cycles with a zero-wait slave (detect, REQ, WAIT), then DONE holds load data.
// Backpressure: d_stall freezes the pipeline while the bus access is outstanding; requests are never withdrawn.
module d_sram_like_bridge
    import d_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_data_en,
    input  logic [3:0]        cpu_data_wen,
    input  logic [31:0]       cpu_data_addr,
    input  logic [31:0]       cpu_data_wdata,
    output logic [31:0]       cpu_data_rdata,
    input  logic              cpu_except,
    input  logic              cpu_longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    bridge_state_t     state;
    logic              cancel;
    logic              accept;
    logic              flush_now;
    logic [1:0]        dec_size;
    logic [ADDR_W-1:0] dec_addr;

    d_bridge_size_dec #(
        .ADDR_W (ADDR_W)
    ) u_size_dec (
        .wen      (cpu_data_wen),
        .addr     (cpu_data_addr),
        .size     (dec_size),
        .bus_addr (dec_addr)
    );

    assign accept    = (state == IDLE) && cpu_data_en && !cpu_except;
    // A flush landing in the same cycle as data_ok must still discard the data.
    assign flush_now = cancel || cpu_except;
    assign d_stall   = accept || (state == REQ) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cancel         <= 1'b0;
            data_req       <= 1'b0;
            data_wr        <= 1'b0;
            data_size      <= 2'd0;
            data_addr      <= '0;
            data_wdata     <= 32'd0;
            cpu_data_rdata <= 32'd0;
            stall_cycles   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_req   <= 1'b1;
                        data_wr    <= |cpu_data_wen;
                        data_size  <= dec_size;
                        data_addr  <= dec_addr;
                        data_wdata <= cpu_data_wdata;
                        cancel     <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (cpu_except) begin
                        cancel <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cpu_except) begin
                        cancel <= 1'b1;
                    end
                    if (data_data_ok) begin
                        if (!data_wr && !flush_now) begin
                            cpu_data_rdata <= data_rdata;
                        end
                        cancel <= 1'b0;
                        state  <= flush_now ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (!cpu_longest_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (d_stall) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
        end
    end

    a_ok_overlap: assert property (@(posedge clk) disable iff (rst)
        !(data_addr_ok && data_data_ok));
    a_early_data: assert property (@(posedge clk) disable iff (rst)
        !((state == REQ) && data_data_ok));
    a_wen_legal:  assert property (@(posedge clk) disable iff (rst)
        accept |-> wen_legal(cpu_data_wen));

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed + randomized bench for d_sram_like_bridge; the bench plays the bus slave
// and keeps a transaction-level model of bus fields, load data and stall count.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_data_en;
    logic [3:0]  cpu_data_wen;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [31:0] cpu_data_rdata;
    logic        cpu_except;
    logic        cpu_longest_stall;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    d_sram_like_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_data_en       (cpu_data_en),
        .cpu_data_wen      (cpu_data_wen),
        .cpu_data_addr     (cpu_data_addr),
        .cpu_data_wdata    (cpu_data_wdata),
        .cpu_data_rdata    (cpu_data_rdata),
        .cpu_except        (cpu_except),
        .cpu_longest_stall (cpu_longest_stall),
        .d_stall           (d_stall),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .stall_cycles      (stall_cycles)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_reqs  = 0;
    int          req_rises = 0;
    logic        prev_req  = 1'b0;

    always @(negedge clk) begin
        if (data_req === 1'b1 && prev_req === 1'b0) req_rises++;
        prev_req = data_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [3:0] wen);
        logic [31:0] p;
        p = a;
`ifdef D_BRIDGE_KSEG_MAP_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) p = a & 32'h1FFF_FFFF;
`endif
        if (wen == 4'b0000) p = (p / 4) * 4;
        return p;
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] wen);
        if (wen == 4'd1 || wen == 4'd2 || wen == 4'd4 || wen == 4'd8) return 2'd0;
        if (wen == 4'd3 || wen == 4'd12) return 2'd1;
        return 2'd2;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"},   data_req, 0);
        chk({tag, "_wr"},    data_wr, 0);
        chk({tag, "_size"},  data_size, 0);
        chk({tag, "_addr"},  data_addr, 0);
        chk({tag, "_wdata"}, data_wdata, 0);
        chk({tag, "_rdata"}, cpu_data_rdata, 0);
        chk({tag, "_cnt"},   stall_cycles, 0);
        chk({tag, "_stall"}, d_stall, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_data_en = 0; cpu_except = 0; data_addr_ok = 0; data_data_ok = 0;
        @(negedge clk);
        exp_stall = 0;
        exp_rdata = 32'd0;
        check_reset_state("rst");
        rst = 1'b0;
    endtask

    // One CPU access. exc / rst_at index the post-detect cycles (0 = first REQ cycle); -1 disables.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int aok, input int dok, input int exc,
                          input int hold, input int rst_at);
        logic [31:0] ea = m_addr(addr, wen);
        logic [1:0]  es = m_size(wen);
        logic        ew = (wen != 4'b0000);
        int          c = 0;
        bit          cancelled = 0;
        @(negedge clk);
        chk("idle_cnt", stall_cycles, exp_stall);
        cpu_data_en = 1; cpu_data_wen = wen; cpu_data_addr = addr; cpu_data_wdata = wdata;
        cpu_except = 0; cpu_longest_stall = 1;
        #1 chk("idle_dstall", d_stall, 1);
        exp_stall++;
        exp_reqs++;
        for (int k = 0; k <= aok; k++) begin
            @(negedge clk);
            if (c == rst_at) begin do_reset(); return; end
            chk("req_vld", data_req, 1);
            chk("req_wr", data_wr, ew);
            chk("req_size", data_size, es);
            chk("req_addr", data_addr, ea);
            if (ew) chk("req_wdata", data_wdata, wdata);
            chk("req_dstall", d_stall, 1);
            chk("req_cnt", stall_cycles, exp_stall);
            exp_stall++;
            data_addr_ok = (k == aok);
            if (c == exc) begin cpu_except = 1; cpu_data_en = 0; cancelled = 1; end
            else cpu_except = 0;
            c++;
        end
        for (int k = 0; k <= dok; k++) begin
            @(negedge clk);
            if (c == rst_at) begin do_reset(); return; end
            chk("wait_req_low", data_req, 0);
            chk("wait_dstall", d_stall, 1);
            chk("wait_cnt", stall_cycles, exp_stall);
            exp_stall++;
            data_addr_ok = 0;
            data_data_ok = (k == dok);
            data_rdata   = (k == dok) ? rd : $urandom;
            if (c == exc) begin cpu_except = 1; cpu_data_en = 0; cancelled = 1; end
            else cpu_except = 0;
            c++;
        end
        if (!ew && !cancelled) exp_rdata = rd;
        @(negedge clk);
        data_data_ok = 0; cpu_except = 0; data_rdata = $urandom;
        if (cancelled) begin
            cpu_data_en = 0; cpu_longest_stall = 0;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                #1 chk("cxl_dstall", d_stall, 0);
                chk("cxl_req", data_req, 0);
                chk("cxl_rdata", cpu_data_rdata, exp_rdata);
                chk("cxl_cnt", stall_cycles, exp_stall);
            end
        end else begin
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                chk("done_dstall", d_stall, 0);
                chk("done_req", data_req, 0);
                chk("done_rdata", cpu_data_rdata, exp_rdata);
                chk("done_cnt", stall_cycles, exp_stall);
                cpu_longest_stall = (h < hold);
                cpu_data_en       = (h < hold);
            end
            @(negedge clk);
            #1 chk("post_dstall", d_stall, 0);
            chk("post_req", data_req, 0);
        end
        chk("req_count", req_rises, exp_reqs);
    endtask

    logic [3:0] legal_wen [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin
        int snap;
        rst = 1; cpu_data_en = 0; cpu_data_wen = 0; cpu_data_addr = 0; cpu_data_wdata = 0;
        cpu_except = 0; cpu_longest_stall = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        @(negedge clk);
        do_reset();

        // Zero-wait read: three stall cycles, load data returned.
        snap = exp_stall;
        access(4'b0000, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, 0, -1);
        chk("t1_stall3", stall_cycles, snap + 3);
        chk("t1_rdata", cpu_data_rdata, 32'hDEAD_BEEF);

        // Halfword store with a slow addr_ok; load data must be untouched.
        access(4'b1100, 32'h0000_0102, 32'h1234_0000, 32'h5555_5555, 4, 1, -1, 0, -1);
        chk("t2_rdata_kept", cpu_data_rdata, 32'hDEAD_BEEF);

        // Read that sits in DONE for 5 stalled cycles with en held high.
        access(4'b0000, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 1, 2, -1, 5, -1);

        // Flush while waiting for data.
        access(4'b0000, 32'h0000_3000, 32'h0, 32'h0BAD_0BAD, 0, 2, 2, 0, -1);
        chk("t4_rdata_kept", cpu_data_rdata, 32'hCAFE_F00D);

        // Excepting access in IDLE never reaches the bus.
        @(negedge clk);
        cpu_data_en = 1; cpu_except = 1; cpu_data_wen = 4'b0000;
        #1 chk("t5_dstall", d_stall, 0);
        @(negedge clk);
        chk("t5_req", data_req, 0);
        chk("t5_cnt", stall_cycles, exp_stall);
        cpu_data_en = 0; cpu_except = 0;
        chk("t5_req_count", req_rises, exp_reqs);

        // Reset in the middle of WAIT.
        access(4'b0000, 32'h0000_4000, 32'h0, 32'h7777_7777, 0, 3, -1, 0, 2);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  w;
            logic [31:0] a;
            int          aok, dok, exc;
            w   = ($urandom_range(0, 1) == 0) ? 4'b0000 : legal_wen[$urandom_range(1, 7)];
            a   = $urandom;
            aok = $urandom_range(0, 3);
            dok = $urandom_range(0, 3);
            exc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, aok + dok + 1) : -1;
            access(w, a, $urandom, $urandom, aok, dok, exc, $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
